// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer
//
// Debug memory dump engine. On i_start it walks a range of 32-bit
// data-memory words through the debug read port and captures each word.
// It then sends the captured word as four bytes, least-significant byte
// first, to the debug UART transmitter.
//
// Handshake: a byte moves on every rising edge where o_tx_valid and
// i_tx_ready are both high. Once o_tx_valid rises, o_tx_valid and o_tx_data
// stay stable until that handshake, an abort or a reset. o_tx_valid is
// decoded from registered state only, so it never depends on i_tx_ready.
//
// Ports:
//   i_clk, i_reset_n  clock; asynchronous active-low reset
//   i_start           dump request, sampled only while idle
//   i_abort           synchronous abort, returns to idle from any state
//   i_base_addr       first byte address (bits [1:0] ignored)
//   i_num_words       number of words to dump (0 = empty dump)
//   o_du_mem_addr     registered debug read address
//   i_du_mem_data     combinational read data {m[a+3],m[a+2],m[a+1],m[a]}
//   o_tx_data         byte to transmitter
//   o_tx_valid        o_tx_data valid
//   i_tx_ready        transmitter ready
//   o_busy            high while loading, sending or completing
//   o_done            one-cycle completion pulse (not raised on abort)
module mem_dump_streamer #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-2:0] i_num_words,
  output logic [ADDR_W-1:0] o_du_mem_addr,
  input  logic [31:0]       i_du_mem_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-2:0] remaining;
  logic [31:0]       word;
  logic [1:0]        idx;

  logic handshake;
  logic last_byte;
  logic last_word;

  assign handshake = (state == SEND) && i_tx_ready;
  assign last_byte = (idx == 2'd3);
  assign last_word = (remaining == (ADDR_W-1)'(1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      idx       <= '0;
    end else if (i_abort) begin
      // Abort wins over every transition. A byte handshaking in this same
      // cycle has already been taken by the transmitter, so nothing to undo.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_num_words != '0) begin
              // Word-align by masking the two low address bits.
              addr      <= i_base_addr & ~ADDR_W'(3);
              remaining <= i_num_words;
              state     <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        LOAD: begin
          // Capture the whole word now; later memory writes cannot tear it.
          word  <= i_du_mem_data;
          idx   <= 2'd0;
          state <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (!last_byte) begin
              idx <= idx + 2'd1;
            end else if (!last_word) begin
              remaining <= remaining - (ADDR_W-1)'(1);
              // Address wraps modulo the memory size.
              addr      <= addr + ADDR_W'(4);
              state     <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_du_mem_addr = addr;
  assign o_tx_data     = word[{idx, 3'b000} +: 8];
  assign o_tx_valid    = (state == SEND);
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);

endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb_mem_dump_streamer
//
// Bench for mem_dump_streamer. A byte-array memory model feeds the debug
// read port. For each dump the expected byte stream is computed up front
// from the memory contents (word k at aligned base + 4k, bytes low first),
// and a negedge monitor compares every handshaken byte against that queue
// and checks that valid/data hold steady across stalls.
module tb_mem_dump_streamer;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_base_addr;
  logic [6:0]  i_num_words;
  logic [7:0]  o_du_mem_addr;
  logic [31:0] du_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  mem_dump_streamer #(.ADDR_W(8)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_base_addr   (i_base_addr),
    .i_num_words   (i_num_words),
    .o_du_mem_addr (o_du_mem_addr),
    .i_du_mem_data (du_data),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [256];

  always_comb begin
    du_data = {mem[o_du_mem_addr + 8'd3], mem[o_du_mem_addr + 8'd2],
               mem[o_du_mem_addr + 8'd1], mem[o_du_mem_addr]};
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_q[$];
  int          hs_cnt;
  logic [31:0] first_word;
  bit          mon_en;
  bit          stall_pend;
  logic [7:0]  held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected stream from the memory contents as they are at launch time.
  task automatic build_exp(input logic [7:0] base, input int num);
    logic [7:0] a;
    exp_q.delete();
    a = base & 8'hFC;
    for (int k = 0; k < num; k++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(mem[8'(int'(a) + 4 * k + b)]);
    hs_cnt = 0;
    first_word = '0;
  endtask

  always @(negedge i_clk) begin
    if (!mon_en || !i_reset_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", {31'd0, o_tx_valid}, 32'd1);
        check("stall_data", {24'd0, o_tx_data}, {24'd0, held});
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (hs_cnt < 4) first_word[8 * hs_cnt +: 8] = o_tx_data;
        hs_cnt++;
      end
      stall_pend = o_tx_valid && !i_tx_ready && !i_abort;
      held = o_tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_dump(input logic [7:0] base, input int num, input int rmode,
                          input bit extra, input int exp_done, input string name);
    int cyc, done_cyc, budget, stall;
    build_exp(base, num);
    i_base_addr = base;
    i_num_words = 7'(num);
    i_start = 1'b1;
    i_tx_ready = 1'b1;
    tick();
    i_start = 1'b0;
    i_base_addr = 8'($urandom);
    cyc = 1;
    done_cyc = -1;
    stall = 0;
    budget = 60 * num + 20;
    while (cyc < budget) begin
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      if (extra && cyc == 3) begin
        i_start = 1'b1;
        i_base_addr = 8'h55;
        i_num_words = 7'd9;
      end else begin
        i_start = 1'b0;
      end
      if (rmode == 0) i_tx_ready = 1'b1;
      else if (stall > 0) begin
        i_tx_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 7) == 0) begin
        i_tx_ready = 1'b0;
        stall = 4;
      end else i_tx_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    i_start = 1'b0;
    i_tx_ready = 1'b0;
    check({name, "_done_seen"}, {31'd0, done_cyc > 0}, 32'd1);
    if (exp_done > 0) check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, "_handshakes"}, 32'(hs_cnt), 32'(4 * num));
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    tick();
    check({name, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
    check({name, "_idle_done"}, {31'd0, o_done}, 32'd0);
  endtask

  // Cycle-exact run with ready held high: timing derived from the
  // 5-cycles-per-word schedule. Mutates the in-flight word mid-send.
  task automatic cycle_exact(input logic [7:0] base, input int num, input string name);
    logic [7:0] a;
    int last;
    a = base & 8'hFC;
    build_exp(base, num);
    last = 5 * num + 1;
    i_base_addr = base;
    i_num_words = 7'(num);
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      check({name, "_busy"}, {31'd0, o_busy}, {31'd0, c <= last});
      check({name, "_done"}, {31'd0, o_done}, {31'd0, c == last});
      check({name, "_valid"}, {31'd0, o_tx_valid},
            {31'd0, (c >= 2) && (c <= 5 * num) && ((c - 1) % 5 != 0)});
      if ((c - 1) % 5 == 0 && c <= 5 * num)
        check({name, "_addr"}, {24'd0, o_du_mem_addr}, {24'd0, 8'(int'(a) + 4 * ((c - 1) / 5))});
      if (c == 3 && num > 0) mem[8'(a + 8'd3)] = ~mem[8'(a + 8'd3)];
      tick();
    end
    i_tx_ready = 1'b0;
    check({name, "_handshakes"}, 32'(hs_cnt), 32'(4 * num));
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  base;
    int          num;
    int          rmode;
    bit          extra;
    int          exp_done;
    bit          chk_first;
    logic [31:0] first;
  } vec_t;

  vec_t tbl[7];

  initial begin
    mon_en = 1'b0;
    i_reset_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_base_addr = '0;
    i_num_words = '0;
    i_tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h44; mem[1] = 8'h33; mem[2] = 8'h22; mem[3] = 8'h11;
    mem[4] = 8'hDD; mem[5] = 8'hCC; mem[6] = 8'hBB; mem[7] = 8'hAA;
    mem[8'hFC] = 8'h04; mem[8'hFD] = 8'h03; mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h01;

    tbl[0] = '{8'h00, 2,  0, 1'b0, 11,  1'b1, 32'h1122_3344};
    tbl[1] = '{8'h00, 2,  1, 1'b0, 0,   1'b1, 32'h1122_3344};
    tbl[2] = '{8'hFD, 2,  0, 1'b0, 11,  1'b1, 32'h0102_0304};
    tbl[3] = '{8'h10, 0,  0, 1'b0, 1,   1'b0, 32'h0};
    tbl[4] = '{8'h40, 3,  0, 1'b1, 16,  1'b0, 32'h0};
    tbl[5] = '{8'hF0, 70, 0, 1'b0, 351, 1'b0, 32'h0};
    tbl[6] = '{8'h13, 5,  1, 1'b1, 0,   1'b0, 32'h0};

    // Reset state
    #12;
    check("rst_addr", {24'd0, o_du_mem_addr}, 32'd0);
    check("rst_data", {24'd0, o_tx_data}, 32'd0);
    check("rst_valid", {31'd0, o_tx_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Table-driven dumps
    for (int i = 0; i < 7; i++) begin
      run_dump(tbl[i].base, tbl[i].num, tbl[i].rmode, tbl[i].extra, tbl[i].exp_done,
               $sformatf("vec%0d", i));
      if (tbl[i].chk_first)
        check($sformatf("vec%0d_first_word", i), first_word, tbl[i].first);
    end

    // Cycle-exact: basic, wrap/alignment, empty
    cycle_exact(8'h00, 2, "basic");
    mem[0] = 8'h08; mem[1] = 8'h07; mem[2] = 8'h06; mem[3] = 8'h05;
    mem[8'hFF] = 8'h01;
    cycle_exact(8'hFD, 2, "wrap");
    cycle_exact(8'h00, 0, "empty");

    // Abort after byte 2 of word 0 (the coinciding handshake counts)
    build_exp(8'h20, 1);
    void'(exp_q.pop_back());
    i_base_addr = 8'h20;
    i_num_words = 7'd3;
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_valid", {31'd0, o_tx_valid}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("abort_quiet", {30'd0, o_done, o_busy}, 32'd0);
      tick();
    end
    check("abort_handshakes", 32'(hs_cnt), 32'd3);
    check("abort_queue_left", 32'(exp_q.size()), 32'd0);
    run_dump(8'h30, 2, 0, 1'b0, 11, "after_abort");

    // Asynchronous reset mid-byte with ready low
    exp_q.delete();
    i_base_addr = 8'h80;
    i_num_words = 7'd2;
    i_tx_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    #3;
    mon_en = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {o_du_mem_addr, o_tx_data, 13'd0, o_tx_valid, o_busy, o_done},
          32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_idle", {30'd0, o_busy, o_tx_valid}, 32'd0);
    end
    run_dump(8'h84, 3, 1, 1'b0, 0, "after_reset");

    // Random dumps over random memory
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) mem[$urandom_range(0, 255)] = 8'($urandom);
      run_dump(8'($urandom), $urandom_range(0, 12), 1, 1'($urandom_range(0, 1)), 0,
               $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
